// File: rtl/tag_alloc_pkg.sv
// rtl/tag_alloc_pkg.sv - shared types and helpers for the tag allocator
package tag_alloc_pkg;

    localparam int TAG_NUM   = 32;
    localparam int TAG_IDX_W = $clog2(TAG_NUM);
    localparam int TAG_CNT_W = $clog2(TAG_NUM + 1);

    typedef logic [TAG_IDX_W-1:0] tag_t;
    typedef logic [TAG_CNT_W-1:0] cnt_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_state_e;

    // Tag successor modulo w; correct for non-power-of-two tag counts.
    function automatic int unsigned tag_inc(input int unsigned tag, input int unsigned w);
        return (tag + 1 == w) ? 0 : tag + 1;
    endfunction

endpackage

// File: rtl/tag_alloc_pick.sv
// rtl/tag_alloc_pick.sv - circular first-zero search starting at ptr
module tag_alloc_pick #(
    parameter int W  = 32,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]  busy_i,
    input  logic [IW-1:0] ptr_i,
    output logic [W-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [W-1:0] below;
    logic [W-1:0] masked;
    logic [W-1:0] oh_masked;
    logic [W-1:0] oh_plain;

    // Indices below ptr are forced busy so the first pass only sees ptr..W-1;
    // adding one carries through the trailing ones and lands on the first zero.
    always_comb begin
        below = '0;
        for (int i = 0; i < W; i++) begin
            below[i] = (i < int'(ptr_i));
        end
        masked    = busy_i | below;
        oh_masked = ~masked & (masked + W'(1));
        oh_plain  = ~busy_i & (busy_i + W'(1));
        onehot_o  = (|oh_masked) ? oh_masked : oh_plain;
        any_o     = ~&busy_i;
    end

    // One-hot to binary encode.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < W; i++) begin
            if (onehot_o[i]) idx_o = idx_o | IW'(i);
        end
    end

endmodule

// File: rtl/tag_alloc.sv
// rtl/tag_alloc.sv - round-robin tag allocator; optional checks under TAG_ALLOC_CHECK_EN
module tag_alloc
    import tag_alloc_pkg::*;
#(
    parameter int W = TAG_NUM
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    output logic                   alloc_vld_o,
    input  logic                   alloc_rdy_i,
    output logic [$clog2(W)-1:0]   alloc_tag_o,
    input  logic                   free_vld_i,
    input  logic [$clog2(W)-1:0]   free_tag_i,
    output logic [$clog2(W+1)-1:0] free_cnt_o,
    output logic                   err_o
);

    localparam int IW = $clog2(W);
    localparam int CW = $clog2(W + 1);
    localparam logic [IW:0] W_L = (IW + 1)'(W);

    if (W < 2) begin : g_w_check
        $error("tag_alloc: W must be greater than 1");
    end

    stage_state_e  state_q, state_d;
    logic [IW-1:0] stage_tag_q, stage_tag_d;
    logic [W-1:0]  busy_q, busy_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [W-1:0]  pick_oh;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          hs;
    logic          load;
    logic          tag_ok;
    logic          free_eff;

    tag_alloc_pick #(.W(W), .IW(IW)) u_pick (
        .busy_i   (busy_q),
        .ptr_i    (ptr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    assign tag_ok = {1'b0, free_tag_i} < W_L;

`ifdef TAG_ALLOC_CHECK_EN
    logic illegal;
    logic err_q;

    // Freeing an unowned tag or the tag still sitting in the stage is refused.
    assign illegal  = free_vld_i && (!tag_ok || !busy_q[free_tag_i] ||
                      (state_q == FULL && free_tag_i == stage_tag_q));
    assign free_eff = free_vld_i && !illegal;

    // Sticky error: only reset clears it, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst)                       err_q <= 1'b0;
        else if (!flush_i && illegal)  err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign free_eff = free_vld_i && tag_ok;
    assign err_o    = 1'b0;
`endif

    assign hs   = (state_q == FULL) && alloc_rdy_i;
    assign load = pick_any && ((state_q == EMPTY) || hs);

    // Stage FSM next state plus busy/ptr/count bookkeeping.
    always_comb begin
        state_d     = state_q;
        stage_tag_d = stage_tag_q;
        busy_d      = busy_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        if (flush_i) begin
            busy_d  = '0;
            state_d = EMPTY;
            ptr_d   = '0;
            cnt_d   = CW'(W);
        end else begin
            if (free_eff) busy_d[free_tag_i] = 1'b0;
            if (load) begin
                busy_d[pick_idx] = 1'b1;
                stage_tag_d      = pick_idx;
                ptr_d            = IW'(tag_inc(32'(pick_idx), W));
                state_d          = FULL;
            end else if (hs) begin
                state_d = EMPTY;
            end
            case ({free_eff, load})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            stage_tag_q <= '0;
            busy_q      <= '0;
            ptr_q       <= '0;
            cnt_q       <= CW'(W);
        end else begin
            state_q     <= state_d;
            stage_tag_q <= stage_tag_d;
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign alloc_vld_o = (state_q == FULL);
    assign alloc_tag_o = stage_tag_q;
    assign free_cnt_o  = cnt_q;

endmodule
